// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage conditional branches against the ID-stage prediction and
// drives the predictor update, mispredict flush/redirect and perf counters.
module branch_resolve_unit #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              id_branch_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic [ADDR_W-1:0] id_target_i,
  input  logic              predict_i,
  input  logic              ex_taken_i,
  output logic              id_take_o,
  output logic              branch_o,
  output logic              update_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  typedef enum logic {
    IDLE,
    RESOLVED_HOLD
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(4);

  state_t            state;
  logic              ex_valid;
  logic              ex_pred;
  logic [ADDR_W-1:0] ex_fall;
  logic [ADDR_W-1:0] ex_tgt;

  logic              resolved;
  logic              fire;
  logic              miss;

  assign resolved = (state == RESOLVED_HOLD);
  assign fire     = ex_valid & ~resolved;
  assign miss     = fire & (ex_pred != ex_taken_i);

  assign branch_o      = fire;
  assign update_o      = fire & ex_taken_i;
  assign flush_o       = miss;
  assign redirect_o    = miss;
  assign redirect_pc_o = miss ? (ex_taken_i ? ex_tgt : ex_fall) : '0;

  // A mispredict in EX squashes whatever ID was about to redirect to.
  assign id_take_o = id_branch_i & predict_i & ~miss;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid <= 1'b0;
      ex_pred  <= 1'b0;
      ex_fall  <= '0;
      ex_tgt   <= '0;
    end else if (miss) begin
      ex_valid <= 1'b0;
    end else if (!stall_i) begin
      ex_valid <= id_branch_i;
      ex_pred  <= predict_i;
      ex_fall  <= id_pc_i + INSN_BYTES;
      ex_tgt   <= id_target_i;
    end
  end

  // RESOLVED_HOLD masks a stalled branch that already fired, so it fires once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fire && stall_i && !miss) state <= RESOLVED_HOLD;
        end
        RESOLVED_HOLD: begin
          if (!stall_i || miss) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      if (fire && branch_cnt_o != CNT_MAX) branch_cnt_o <= branch_cnt_o + 1'b1;
      if (miss && miss_cnt_o != CNT_MAX)   miss_cnt_o   <= miss_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed checks of branch_resolve_unit against a
// cycle-level behavioural model of branch slots and perf counts.
module tb_branch_resolve_unit;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_i;
  logic              rst_i;
  logic              stall_i;
  logic              id_branch_i;
  logic [ADDR_W-1:0] id_pc_i;
  logic [ADDR_W-1:0] id_target_i;
  logic              predict_i;
  logic              ex_taken_i;
  logic              id_take_o;
  logic              branch_o;
  logic              update_o;
  logic              flush_o;
  logic              redirect_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  miss_cnt_o;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .id_branch_i(id_branch_i), .id_pc_i(id_pc_i), .id_target_i(id_target_i),
    .predict_i(predict_i), .ex_taken_i(ex_taken_i), .id_take_o(id_take_o),
    .branch_o(branch_o), .update_o(update_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model: the branch currently occupying EX and whether it was already reported.
  typedef struct {
    bit              valid;
    bit              pred;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tgt;
    bit              reported;
  } slot_t;

  slot_t m_slot;
  int    m_bcnt;
  int    m_mcnt;

  logic              obs_branch;
  logic              obs_flush;
  logic              obs_idtake;
  logic [ADDR_W-1:0] obs_rpc;
  int                obs_bcnt;
  int                obs_mcnt;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_slot = '{valid: 1'b0, pred: 1'b0, pc: '0, tgt: '0, reported: 1'b0};
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  // One clock cycle: drive ID/EX inputs, check every output against the model,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                               input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt,
                               input logic pred, input logic taken);
    bit e_fire, e_miss;
    logic [ADDR_W-1:0] e_rpc;
    @(negedge clk_i);
    rst_i = rst; stall_i = stall; id_branch_i = br; id_pc_i = pc;
    id_target_i = tgt; predict_i = pred; ex_taken_i = taken;
    #1;
    if (!rst) modelReset();
    e_fire = m_slot.valid && !m_slot.reported;
    e_miss = e_fire && (m_slot.pred != taken);
    e_rpc  = '0;
    if (e_miss) e_rpc = taken ? m_slot.tgt : m_slot.pc + 32'd4;

    checkOutput("branch_o",      branch_o,      e_fire);
    checkOutput("update_o",      update_o,      e_fire && taken);
    checkOutput("flush_o",       flush_o,       e_miss);
    checkOutput("redirect_o",    redirect_o,    e_miss);
    checkOutput("redirect_pc_o", redirect_pc_o, e_rpc);
    checkOutput("id_take_o",     id_take_o,     br && pred && !e_miss);
    checkOutput("branch_cnt_o",  branch_cnt_o,  m_bcnt);
    checkOutput("miss_cnt_o",    miss_cnt_o,    m_mcnt);

    obs_branch = branch_o; obs_flush = flush_o; obs_idtake = id_take_o;
    obs_rpc = redirect_pc_o; obs_bcnt = int'(branch_cnt_o); obs_mcnt = int'(miss_cnt_o);

    if (rst) begin
      if (e_fire && m_bcnt < CMAX) m_bcnt++;
      if (e_miss && m_mcnt < CMAX) m_mcnt++;
      if (e_miss) begin
        m_slot.valid = 1'b0;
        m_slot.reported = 1'b0;
      end else if (stall) begin
        m_slot.reported = m_slot.reported || e_fire;
      end else begin
        m_slot = '{valid: br, pred: pred, pc: pc, tgt: tgt, reported: 1'b0};
      end
    end
    @(posedge clk_i);
  endtask

  task automatic idle(input logic stall, input logic taken);
    applyStimulus(1'b1, stall, 1'b0, '0, '0, 1'b0, taken);
  endtask

  int pulses;

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; id_branch_i = 1'b0; id_pc_i = '0;
    id_target_i = '0; predict_i = 1'b0; ex_taken_i = 1'b0;
    modelReset();

    // Reset held with active stimulus
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h140, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 32'h140, 1'b1, 1'b0);
    checkOutput("rst_bcnt", obs_bcnt, 0);
    checkOutput("rst_idtake", obs_idtake, 1);

    // Correct prediction
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'h140, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    checkOutput("corr_branch", obs_branch, 1);
    checkOutput("corr_flush", obs_flush, 0);
    idle(1'b0, 1'b0);
    checkOutput("corr_bcnt", obs_bcnt, 1);
    checkOutput("corr_mcnt", obs_mcnt, 0);

    // Mispredict: predicted taken, actually falls through
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'h180, 1'b1, 1'b0);
    idle(1'b0, 1'b0);
    checkOutput("miss_flush", obs_flush, 1);
    checkOutput("miss_rpc", obs_rpc, 32'h204);
    idle(1'b0, 1'b0);
    checkOutput("miss_after_branch", obs_branch, 0);
    checkOutput("miss_mcnt", obs_mcnt, 1);

    // Stall while the branch sits in EX
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'h340, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b0);
      pulses += int'(obs_branch);
    end
    idle(1'b0, 1'b0);
    pulses += int'(obs_branch);
    checkOutput("stall_pulses", pulses, 1);
    checkOutput("stall_bcnt", obs_bcnt, 3);

    // Back-to-back: older branch mispredicts, younger one in ID predicts taken
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h400, 32'h480, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h500, 32'h540, 1'b1, 1'b1);
    checkOutput("b2b_idtake", obs_idtake, 0);
    checkOutput("b2b_rpc", obs_rpc, 32'h480);
    idle(1'b0, 1'b1);
    checkOutput("b2b_young_branch", obs_branch, 0);
    idle(1'b0, 1'b0);
    checkOutput("b2b_bcnt", obs_bcnt, 4);

    // Reset in the middle of a stalled resolution
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h600, 32'h640, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    checkOutput("rst_mid_branch", obs_branch, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(99) != 0), ($urandom_range(9) < 3),
                    1'($urandom), {$urandom_range(32'h3fff_ffff), 2'b00}, $urandom,
                    1'($urandom), 1'($urandom));
    end

    // Saturation: 20 mispredicts
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i * 16), 32'h2000, 1'b1, 1'b0);
      idle(1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);
    checkOutput("sat_bcnt", obs_bcnt, CMAX);
    checkOutput("sat_mcnt", obs_mcnt, CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
